// File: rtl/wb_pkg.sv
// Shared Wishbone definitions for the GPIO interconnect slice:
// arbiter state encoding and default bus widths.
package wb_pkg;

  localparam int unsigned WB_DAT_WIDTH_DEF = 16;
  localparam int unsigned WB_ADR_WIDTH_DEF = 14;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUSY  = 2'd1,
    ABORT = 2'd2
  } arb_state_t;

endpackage

// File: rtl/rr_priority_pick.sv
// Combinational round-robin selector: picks the first requester above
// the last-granted index, wrapping around; reusable for any shared port.
module rr_priority_pick #(
  parameter int unsigned N = 2
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] last,
  output logic [N-1:0]         gnt,
  output logic [$clog2(N)-1:0] idx,
  output logic                 valid
);

  localparam int unsigned IW = $clog2(N);

  always_comb begin
    int unsigned k;
    logic [IW-1:0] kk;
    gnt   = '0;
    idx   = '0;
    valid = 1'b0;
    k     = 0;
    kk    = '0;
    // Offsets 1..N visit every index once, ending on last itself.
    for (int unsigned i = 1; i <= N; i++) begin
      k  = (32'(last) + i) % N;
      kk = IW'(k);
      if (!valid && req[kk]) begin
        valid   = 1'b1;
        gnt[kk] = 1'b1;
        idx     = kk;
      end
    end
  end

endmodule

// File: rtl/wb_gpio_arbiter.sv
// Round-robin Wishbone arbiter sharing one GPIO slave between several
// masters; grant held for the whole cyc, stalled transfers errored.
module wb_gpio_arbiter
  import wb_pkg::*;
#(
  parameter int unsigned NUM_MASTERS    = 2,
  parameter int unsigned WB_DAT_WIDTH   = WB_DAT_WIDTH_DEF,
  parameter int unsigned WB_ADR_WIDTH   = WB_ADR_WIDTH_DEF,
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [NUM_MASTERS-1:0]            m_cyc_i,
  input  logic [NUM_MASTERS-1:0]            m_stb_i,
  input  logic [NUM_MASTERS-1:0]            m_we_i,
  input  logic [NUM_MASTERS*WB_ADR_WIDTH-1:0] m_adr_i,
  input  logic [NUM_MASTERS*WB_DAT_WIDTH-1:0] m_dat_i,
  output logic [WB_DAT_WIDTH-1:0]           m_dat_o,
  output logic [NUM_MASTERS-1:0]            m_ack_o,
  output logic [NUM_MASTERS-1:0]            m_err_o,
  output logic                              s_cyc_o,
  output logic                              s_stb_o,
  output logic                              s_we_o,
  output logic [WB_ADR_WIDTH-1:0]           s_adr_o,
  output logic [WB_DAT_WIDTH-1:0]           s_dat_o,
  input  logic [WB_DAT_WIDTH-1:0]           s_dat_i,
  input  logic                              s_ack_i,
  output logic [NUM_MASTERS-1:0]            gnt_o
);

  localparam int unsigned IDX_W = $clog2(NUM_MASTERS);
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  arb_state_t       state;
  logic [IDX_W-1:0] last;
  logic [CNT_W-1:0] tcnt;

  logic [NUM_MASTERS-1:0] pick_gnt;
  logic [IDX_W-1:0]       pick_idx;
  logic                   pick_valid;
  logic                   stall;
  logic                   timeout;

  logic [WB_ADR_WIDTH-1:0] adr_arr [NUM_MASTERS];
  logic [WB_DAT_WIDTH-1:0] dat_arr [NUM_MASTERS];

  for (genvar g = 0; g < NUM_MASTERS; g++) begin : g_unpack
    assign adr_arr[g] = m_adr_i[g*WB_ADR_WIDTH +: WB_ADR_WIDTH];
    assign dat_arr[g] = m_dat_i[g*WB_DAT_WIDTH +: WB_DAT_WIDTH];
  end

  rr_priority_pick #(
    .N(NUM_MASTERS)
  ) u_pick (
    .req   (m_cyc_i),
    .last  (last),
    .gnt   (pick_gnt),
    .idx   (pick_idx),
    .valid (pick_valid)
  );

  // The last-granted pointer doubles as the owner index in BUSY/ABORT.
  always_comb begin
    s_cyc_o = 1'b0;
    s_stb_o = 1'b0;
    s_we_o  = 1'b0;
    s_adr_o = '0;
    s_dat_o = '0;
    m_ack_o = '0;
    m_err_o = '0;
    m_dat_o = s_dat_i;
    case (state)
      BUSY: begin
        s_cyc_o       = m_cyc_i[last];
        s_stb_o       = m_cyc_i[last] & m_stb_i[last];
        s_we_o        = m_we_i[last];
        s_adr_o       = adr_arr[last];
        s_dat_o       = dat_arr[last];
        m_ack_o[last] = s_ack_i;
      end
      ABORT: m_err_o[last] = 1'b1;
      default: ;
    endcase
  end

  assign stall   = s_stb_o & ~s_ack_i;
  assign timeout = stall && (tcnt == CNT_LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      gnt_o <= '0;
      last  <= IDX_W'(NUM_MASTERS - 1);
      tcnt  <= '0;
    end else begin
      case (state)
        IDLE: begin
          tcnt <= '0;
          if (pick_valid) begin
            state <= BUSY;
            gnt_o <= pick_gnt;
            last  <= pick_idx;
          end
        end
        BUSY: begin
          if (!m_cyc_i[last]) begin
            state <= IDLE;
            gnt_o <= '0;
            tcnt  <= '0;
          end else if (timeout) begin
            state <= ABORT;
            tcnt  <= '0;
          end else if (stall) begin
            tcnt <= tcnt + CNT_W'(1);
          end else begin
            tcnt <= '0;
          end
        end
        ABORT: begin
          state <= IDLE;
          gnt_o <= '0;
          tcnt  <= '0;
        end
        default: begin
          state <= IDLE;
          gnt_o <= '0;
          tcnt  <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wb_gpio_arbiter.sv
// Self-checking bench for wb_gpio_arbiter: vector table, directed
// multi-cycle sequences and randomized traffic against a reference model.
module tb_wb_gpio_arbiter;

  localparam int N  = 2;
  localparam int DW = 16;
  localparam int AW = 14;
  localparam int TO = 8;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    m_cyc_i, m_stb_i, m_we_i;
  logic [AW-1:0]   adr [N];
  logic [DW-1:0]   dat [N];
  logic [N*AW-1:0] m_adr_i;
  logic [N*DW-1:0] m_dat_i;
  logic [DW-1:0]   m_dat_o;
  logic [N-1:0]    m_ack_o, m_err_o, gnt_o;
  logic            s_cyc_o, s_stb_o, s_we_o;
  logic [AW-1:0]   s_adr_o;
  logic [DW-1:0]   s_dat_o;
  logic [DW-1:0]   s_dat_i;
  logic            s_ack_i;

  assign m_adr_i = {adr[1], adr[0]};
  assign m_dat_i = {dat[1], dat[0]};

  always #5 clk = ~clk;

  wb_gpio_arbiter #(
    .NUM_MASTERS    (N),
    .WB_DAT_WIDTH   (DW),
    .WB_ADR_WIDTH   (AW),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .m_cyc_i (m_cyc_i),
    .m_stb_i (m_stb_i),
    .m_we_i  (m_we_i),
    .m_adr_i (m_adr_i),
    .m_dat_i (m_dat_i),
    .m_dat_o (m_dat_o),
    .m_ack_o (m_ack_o),
    .m_err_o (m_err_o),
    .s_cyc_o (s_cyc_o),
    .s_stb_o (s_stb_o),
    .s_we_o  (s_we_o),
    .s_adr_o (s_adr_o),
    .s_dat_o (s_dat_o),
    .s_dat_i (s_dat_i),
    .s_ack_i (s_ack_i),
    .gnt_o   (gnt_o)
  );

  int passed = 0;
  int total  = 0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, got, exp);
  endtask

  function automatic logic [54:0] outs();
    return {s_cyc_o, s_stb_o, s_we_o, s_adr_o, s_dat_o, m_ack_o, m_err_o, gnt_o, m_dat_o};
  endfunction

  task automatic to_check();
    @(negedge clk);
  endtask

  task automatic to_drive();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic [1:0] c, input logic [1:0] s, input logic [1:0] w, input logic a);
    m_cyc_i = c;
    m_stb_i = s;
    m_we_i  = w;
    s_ack_i = a;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    set_in(2'b00, 2'b00, 2'b00, 1'b0);
    adr[0] = '0; adr[1] = '0; dat[0] = '0; dat[1] = '0; s_dat_i = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    to_drive();
  endtask

  // Reference model: owner (-1 when free), pending abort, round-robin
  // pointer and the length of the current unacknowledged strobe run.
  int mo_owner, mo_last, mo_wait;
  bit mo_abort;

  function automatic logic [54:0] model_out();
    logic          sc = 1'b0, ss = 1'b0, sw = 1'b0;
    logic [AW-1:0] a  = '0;
    logic [DW-1:0] d  = '0;
    logic [N-1:0]  ak = '0, er = '0, g = '0;
    if (mo_owner >= 0) g[mo_owner] = 1'b1;
    if (mo_abort) er[mo_owner] = 1'b1;
    else if (mo_owner >= 0) begin
      sc = m_cyc_i[mo_owner];
      ss = sc & m_stb_i[mo_owner];
      sw = m_we_i[mo_owner];
      a  = adr[mo_owner];
      d  = dat[mo_owner];
      ak[mo_owner] = s_ack_i;
    end
    return {sc, ss, sw, a, d, ak, er, g, s_dat_i};
  endfunction

  task automatic model_edge();
    if (mo_abort) begin
      mo_abort = 1'b0;
      mo_owner = -1;
      mo_wait  = 0;
    end else if (mo_owner >= 0) begin
      if (!m_cyc_i[mo_owner]) begin
        mo_owner = -1;
        mo_wait  = 0;
      end else if (m_stb_i[mo_owner] && !s_ack_i) begin
        if (mo_wait == TO - 1) begin
          mo_abort = 1'b1;
          mo_wait  = 0;
        end else mo_wait++;
      end else mo_wait = 0;
    end else begin
      for (int k = 1; k <= N; k++) begin
        int c = (mo_last + k) % N;
        if (m_cyc_i[c]) begin
          mo_owner = c;
          mo_last  = c;
          break;
        end
      end
    end
  endtask

  typedef struct packed {
    logic [1:0]    cyc, stb, we;
    logic [AW-1:0] a0, a1;
    logic [DW-1:0] d0, d1, sd;
    logic          ack;
    logic          e_scyc, e_sstb, e_swe;
    logic [AW-1:0] e_adr;
    logic [DW-1:0] e_sdat;
    logic [1:0]    e_ack, e_err, e_gnt;
    logic [DW-1:0] e_mdat;
  } vec_t;

  vec_t vt [10];

  initial begin
    int stb_cnt;
    bit seen;
    logic [1:0] cyc_r;

    vt[0] = '{2'b01, 2'b01, 2'b01, 14'd1, 14'd0, 16'h00A5, 16'h0000, 16'h0000, 1'b0,
              1'b0, 1'b0, 1'b0, 14'd0, 16'h0000, 2'b00, 2'b00, 2'b00, 16'h0000};
    vt[1] = '{2'b01, 2'b01, 2'b01, 14'd1, 14'd0, 16'h00A5, 16'h0000, 16'h0000, 1'b0,
              1'b1, 1'b1, 1'b1, 14'd1, 16'h00A5, 2'b00, 2'b00, 2'b01, 16'h0000};
    vt[2] = vt[1];
    vt[3] = '{2'b01, 2'b01, 2'b01, 14'd1, 14'd0, 16'h00A5, 16'h0000, 16'h0000, 1'b1,
              1'b1, 1'b1, 1'b1, 14'd1, 16'h00A5, 2'b01, 2'b00, 2'b01, 16'h0000};
    vt[4] = '{2'b00, 2'b00, 2'b00, 14'd1, 14'd0, 16'h00A5, 16'h0000, 16'h0000, 1'b0,
              1'b0, 1'b0, 1'b0, 14'd1, 16'h00A5, 2'b00, 2'b00, 2'b01, 16'h0000};
    vt[5] = '{2'b00, 2'b00, 2'b00, 14'd0, 14'd0, 16'h0000, 16'h0000, 16'h0000, 1'b0,
              1'b0, 1'b0, 1'b0, 14'd0, 16'h0000, 2'b00, 2'b00, 2'b00, 16'h0000};
    vt[6] = '{2'b10, 2'b10, 2'b00, 14'h3FFF, 14'd0, 16'hFFFF, 16'h1234, 16'h0042, 1'b0,
              1'b0, 1'b0, 1'b0, 14'd0, 16'h0000, 2'b00, 2'b00, 2'b00, 16'h0042};
    vt[7] = '{2'b10, 2'b10, 2'b00, 14'h3FFF, 14'd0, 16'hFFFF, 16'h1234, 16'h0042, 1'b1,
              1'b1, 1'b1, 1'b0, 14'd0, 16'h1234, 2'b10, 2'b00, 2'b10, 16'h0042};
    vt[8] = '{2'b00, 2'b00, 2'b00, 14'h3FFF, 14'd0, 16'hFFFF, 16'h1234, 16'h0042, 1'b0,
              1'b0, 1'b0, 1'b0, 14'd0, 16'h1234, 2'b00, 2'b00, 2'b10, 16'h0042};
    vt[9] = vt[5];

    rst = 1'b0;
    set_in(2'b00, 2'b00, 2'b00, 1'b0);
    adr[0] = '0; adr[1] = '0; dat[0] = '0; dat[1] = '0; s_dat_i = '0;
    #1;
    chk("reset_state", 64'(outs()), 64'd0);

    // Vector table: master 0 write with delayed ack, then master 1 read.
    do_reset();
    for (int i = 0; i < 10; i++) begin
      set_in(vt[i].cyc, vt[i].stb, vt[i].we, vt[i].ack);
      adr[0] = vt[i].a0; adr[1] = vt[i].a1;
      dat[0] = vt[i].d0; dat[1] = vt[i].d1;
      s_dat_i = vt[i].sd;
      to_check();
      chk($sformatf("vec%0d", i), 64'(outs()),
          64'({vt[i].e_scyc, vt[i].e_sstb, vt[i].e_swe, vt[i].e_adr, vt[i].e_sdat,
               vt[i].e_ack, vt[i].e_err, vt[i].e_gnt, vt[i].e_mdat}));
      to_drive();
    end

    // Simultaneous requests alternate between masters.
    do_reset();
    set_in(2'b11, 2'b11, 2'b00, 1'b0);
    to_check(); chk("alt_idle_gnt", 64'(gnt_o), 64'd0); to_drive();
    to_check(); chk("alt_first", 64'(gnt_o), 64'b01); to_drive();
    set_in(2'b10, 2'b10, 2'b00, 1'b0);
    to_check(); chk("alt_drop_gate", 64'(s_cyc_o), 64'd0); to_drive();
    to_check(); chk("alt_gap", 64'(gnt_o), 64'd0); to_drive();
    to_check(); chk("alt_second", 64'(gnt_o), 64'b10); to_drive();
    set_in(2'b00, 2'b00, 2'b00, 1'b0);
    to_check(); to_drive();
    to_check(); to_drive();
    set_in(2'b11, 2'b11, 2'b00, 1'b0);
    to_check(); to_drive();
    to_check(); chk("alt_third", 64'(gnt_o), 64'b01); to_drive();

    // Slave never acks: error after TO strobe cycles, then pending master 1.
    do_reset();
    set_in(2'b11, 2'b11, 2'b01, 1'b0);
    to_check(); to_drive();
    stb_cnt = 0;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      to_check();
      if (m_err_o != '0) begin
        seen = 1'b1;
        chk("to_err", 64'(m_err_o), 64'b01);
        chk("to_scyc", 64'(s_cyc_o), 64'd0);
        chk("to_ack", 64'(m_ack_o), 64'd0);
      end else if (s_stb_o && gnt_o == 2'b01) stb_cnt++;
      to_drive();
    end
    chk("to_seen", 64'(seen), 64'd1);
    chk("to_stb_cycles", 64'(stb_cnt), 64'd8);
    to_check();
    chk("to_err_once", 64'(m_err_o), 64'd0);
    chk("to_idle_gnt", 64'(gnt_o), 64'd0);
    to_drive();
    to_check(); chk("to_next", 64'(gnt_o), 64'b10); to_drive();

    // Ack on the final timeout cycle wins over the error.
    do_reset();
    set_in(2'b01, 2'b01, 2'b00, 1'b0);
    to_check(); to_drive();
    for (int i = 0; i < 7; i++) begin
      to_check(); to_drive();
    end
    s_ack_i = 1'b1;
    to_check();
    chk("late_ack", 64'(m_ack_o), 64'b01);
    chk("late_err", 64'(m_err_o), 64'd0);
    to_drive();
    set_in(2'b00, 2'b00, 2'b00, 1'b0);
    to_check();
    chk("late_err_after", 64'(m_err_o), 64'd0);
    chk("late_still_busy", 64'(gnt_o), 64'b01);
    to_drive();
    to_check(); chk("late_idle", 64'({gnt_o, m_err_o}), 64'd0); to_drive();

    // Asynchronous reset mid-transfer; pointer restarts at master 0.
    do_reset();
    set_in(2'b01, 2'b01, 2'b01, 1'b0);
    to_check(); to_drive();
    to_check();
    chk("rst_pre_gnt", 64'(gnt_o), 64'b01);
    chk("rst_pre_scyc", 64'(s_cyc_o), 64'd1);
    #2 rst = 1'b0;
    #1;
    chk("rst_async", 64'({gnt_o, s_cyc_o, s_stb_o, m_ack_o, m_err_o}), 64'd0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    set_in(2'b11, 2'b11, 2'b00, 1'b0);
    to_drive();
    to_check(); chk("rst_first_grant", 64'(gnt_o), 64'b01); to_drive();

    // Randomized traffic against the reference model.
    do_reset();
    mo_owner = -1; mo_last = N - 1; mo_wait = 0; mo_abort = 1'b0;
    cyc_r = '0;
    for (int cy = 0; cy < 1500; cy++) begin
      for (int m = 0; m < N; m++) begin
        if (cyc_r[m]) begin
          if ($urandom_range(7) == 0) cyc_r[m] = 1'b0;
        end else if ($urandom_range(3) == 0) cyc_r[m] = 1'b1;
        adr[m] = AW'($urandom);
        dat[m] = DW'($urandom);
      end
      set_in(cyc_r, 2'($urandom), 2'($urandom), ($urandom_range(5) == 0));
      s_dat_i = DW'($urandom);
      to_check();
      chk($sformatf("rand%0d", cy), 64'(outs()), 64'(model_out()));
      model_edge();
      to_drive();
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
